// File: rtl/bit_serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_alu_seq
// Purpose  : Multi-cycle sequencer around an external 1-bit ALU slice. A
//            WIDTH-bit operation is processed one bit per clock, LSB first.
//            The sequencer supplies operand bits, the carry and the control
//            code to the slice. It collects the slice Result/Cout bits,
//            assembles the result word and derives the zero, overflow and
//            carry flags.
// Ports    : clk, rst_n (synchronous, active low)
//            start/op/opa/opb     - issue interface, sampled in IDLE only
//            busy/done            - status (done is a one-cycle pulse)
//            result/zero/overflow/carry_out - registered, held until the
//                                   next operation completes
//            slice_a/b/cin/less/ctrl - drive to the 1-bit slice
//            slice_cout/slice_result - returns from the 1-bit slice
// Revision : 1.0 - initial release
// ============================================================================
module bit_serial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_less,
    output logic [3:0]       slice_ctrl,
    input  logic             slice_cout,
    input  logic             slice_result
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   acc_q;       // raw slice result bits, filled by index
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               overflow_q;
    logic               carry_out_q;

    // Values that become the new outputs on the final RUN edge.
    logic [WIDTH-1:0]   sum_word_d;
    logic [WIDTH-1:0]   result_d;
    logic               ovf_d;
    logic               set_d;
    logic               is_arith_d;
    logic               is_slt_d;
    logic               run_w;

    assign run_w = (state_q == S_RUN);

    always_comb begin
        is_arith_d = (op_q == OP_ADD) || (op_q == OP_SUB);
        is_slt_d   = (op_q == OP_SLT);
        // The MSB of the sum arrives from the slice during the last cycle,
        // so it is merged in combinationally rather than taken from acc_q.
        sum_word_d            = acc_q;
        sum_word_d[WIDTH-1]   = slice_result;
        // carry_q holds the carry into the MSB during the last cycle.
        ovf_d      = carry_q ^ slice_cout;
        // SLT: sign of (A - B) corrected for signed overflow.
        set_d      = slice_result ^ ovf_d;
        result_d   = is_slt_d ? {{(WIDTH-1){1'b0}}, set_d} : sum_word_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 4'b0000;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_RUN;
                        op_q    <= op;
                        a_q     <= opa;
                        b_q     <= opb;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        // Carry-in of 1 turns the inverted-B add into a subtract.
                        carry_q <= op[2];
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    acc_q[cnt_q] <= slice_result;
                    carry_q      <= slice_cout;
                    if (cnt_q == LAST_BIT) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        result_q    <= result_d;
                        zero_q      <= (result_d == '0);
                        overflow_q  <= is_arith_d & ovf_d;
                        carry_out_q <= is_arith_d & slice_cout;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // No issue from DONE: start is only looked at in IDLE.
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Slice drive: operand bits selected by the counter, quiet outside RUN.
    assign slice_a    = run_w & a_q[cnt_q];
    assign slice_b    = run_w & b_q[cnt_q];
    assign slice_cin  = run_w & carry_q;
    assign slice_less = 1'b0;
    // SLT is executed as a subtract; the set bit is formed here, not in the slice.
    assign slice_ctrl = run_w ? ((op_q == OP_SLT) ? OP_SUB : op_q) : 4'b0000;

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign carry_out = carry_out_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serial_alu_seq
// Purpose  : Directed self-checking bench for bit_serial_alu_seq with an
//            8-bit and a 32-bit instance, each connected to a behavioural
//            1-bit ALU slice.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serial_alu_seq;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // 1-bit ALU slice: {Cout, Result}
    function automatic logic [1:0] slice_model(input logic a, input logic b,
                                               input logic cin, input logic less,
                                               input logic [3:0] c);
        logic aa, bb, s, co, r;
        aa = a ^ c[3];
        bb = b ^ c[2];
        s  = aa ^ bb ^ cin;
        co = (aa & bb) | (aa & cin) | (bb & cin);
        case (c[1:0])
            2'b00:   r = aa & bb;
            2'b01:   r = aa | bb;
            2'b10:   r = s;
            default: r = less;
        endcase
        return {co, r};
    endfunction

    // ---------------- WIDTH = 8 instance ----------------
    logic       start8 = 1'b0;
    logic [3:0] op8 = 4'b0;
    logic [7:0] opa8 = 8'h0, opb8 = 8'h0;
    logic       busy8, done8, zero8, ovf8, cy8;
    logic [7:0] result8;
    logic       sa8, sb8, scin8, sless8, scout8, sres8;
    logic [3:0] sctrl8;

    assign {scout8, sres8} = slice_model(sa8, sb8, scin8, sless8, sctrl8);

    bit_serial_alu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .opa(opa8), .opb(opb8),
        .busy(busy8), .done(done8), .result(result8), .zero(zero8),
        .overflow(ovf8), .carry_out(cy8),
        .slice_a(sa8), .slice_b(sb8), .slice_cin(scin8), .slice_less(sless8),
        .slice_ctrl(sctrl8), .slice_cout(scout8), .slice_result(sres8)
    );

    // ---------------- WIDTH = 32 instance ----------------
    logic        start32 = 1'b0;
    logic [3:0]  op32 = 4'b0;
    logic [31:0] opa32 = 32'h0, opb32 = 32'h0;
    logic        busy32, done32, zero32, ovf32, cy32;
    logic [31:0] result32;
    logic        sa32, sb32, scin32, sless32, scout32, sres32;
    logic [3:0]  sctrl32;

    assign {scout32, sres32} = slice_model(sa32, sb32, scin32, sless32, sctrl32);

    bit_serial_alu_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .opa(opa32), .opb(opb32),
        .busy(busy32), .done(done32), .result(result32), .zero(zero32),
        .overflow(ovf32), .carry_out(cy32),
        .slice_a(sa32), .slice_b(sb32), .slice_cin(scin32), .slice_less(sless32),
        .slice_ctrl(sctrl32), .slice_cout(scout32), .slice_result(sres32)
    );

    // Issue one op on the 8-bit DUT from IDLE; n = edges from the start edge
    // (inclusive) to the first sample with done high; 100 means timed out.
    task automatic run8(input logic [3:0] o, input logic [7:0] a,
                        input logic [7:0] b, output int n);
        op8 = o; opa8 = a; opb8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy8, done8, zero8, ovf8, cy8} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 00000", {busy8, done8, zero8, ovf8, cy8});
        end
        tests_run++;
        if (result8 !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_result: got %h expected 00", result8);
        end
        tests_run++;
        if ({sa8, sb8, scin8, sless8, sctrl8} !== 8'b0) begin
            tests_failed++;
            $display("FAIL reset_slice: got %b expected 00000000", {sa8, sb8, scin8, sless8, sctrl8});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int n;
        op8 = OP_ADD; opa8 = 8'h7F; opb8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        // Bit 0 cycle: A[0]=1, B[0]=1, cin=0, ctrl=ADD
        tests_run++;
        if ({busy8, sa8, sb8, scin8, sctrl8} !== {4'b1110, OP_ADD}) begin
            tests_failed++;
            $display("FAIL add_bit0_drive: got %b expected %b", {busy8, sa8, sb8, scin8, sctrl8}, {4'b1110, OP_ADD});
        end
        n = 1;
        while (!done8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (n !== 9) begin
            tests_failed++;
            $display("FAIL add_latency: got %0d expected 9", n);
        end
        tests_run++;
        if ({result8, ovf8, cy8, zero8} !== {8'h80, 3'b100}) begin
            tests_failed++;
            $display("FAIL add_7f_01: got %h/%b expected 80/100", result8, {ovf8, cy8, zero8});
        end
        @(posedge clk); #1;
        tests_run++;
        if ({done8, busy8, result8} !== {2'b00, 8'h80}) begin
            tests_failed++;
            $display("FAIL add_after_done: got %b/%h expected 00/80", {done8, busy8}, result8);
        end
    endtask

    task automatic test_sub();
        int n;
        run8(OP_SUB, 8'h05, 8'h05, n);
        tests_run++;
        if ({n, result8, zero8, cy8, ovf8} !== {32'd9, 8'h00, 3'b110}) begin
            tests_failed++;
            $display("FAIL sub_5_5: got n=%0d %h z/c/v=%b expected n=9 00 110", n, result8, {zero8, cy8, ovf8});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_slt();
        int n;
        op8 = OP_SLT; opa8 = 8'h80; opb8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        tests_run++;
        if ({scin8, sctrl8} !== {1'b1, OP_SUB}) begin
            tests_failed++;
            $display("FAIL slt_slice_ctrl: got %b expected %b", {scin8, sctrl8}, {1'b1, OP_SUB});
        end
        n = 1;
        while (!done8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if ({n, result8} !== {32'd9, 8'h01}) begin
            tests_failed++;
            $display("FAIL slt_80_01: got n=%0d %h expected n=9 01", n, result8);
        end
        @(posedge clk); #1;
        run8(OP_SLT, 8'h01, 8'h80, n);
        tests_run++;
        if ({n, result8, zero8} !== {32'd9, 8'h00, 1'b1}) begin
            tests_failed++;
            $display("FAIL slt_01_80: got n=%0d %h z=%b expected n=9 00 1", n, result8, zero8);
        end
        @(posedge clk); #1;
        run8(OP_SLT, 8'h7F, 8'h80, n);
        tests_run++;
        if ({n, result8, ovf8, cy8} !== {32'd9, 8'h00, 2'b00}) begin
            tests_failed++;
            $display("FAIL slt_7f_80: got n=%0d %h v/c=%b expected n=9 00 00", n, result8, {ovf8, cy8});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_logic();
        int n;
        run8(OP_NOR, 8'hF0, 8'h0C, n);
        tests_run++;
        if ({n, result8, ovf8, cy8, zero8} !== {32'd9, 8'h03, 3'b000}) begin
            tests_failed++;
            $display("FAIL nor_f0_0c: got n=%0d %h v/c/z=%b expected n=9 03 000", n, result8, {ovf8, cy8, zero8});
        end
        @(posedge clk); #1;
        run8(OP_AND, 8'hF0, 8'h3C, n);
        tests_run++;
        if ({n, result8, ovf8, cy8, zero8} !== {32'd9, 8'h30, 3'b000}) begin
            tests_failed++;
            $display("FAIL and_f0_3c: got n=%0d %h v/c/z=%b expected n=9 30 000", n, result8, {ovf8, cy8, zero8});
        end
        @(posedge clk); #1;
        run8(OP_OR, 8'hF0, 8'h3C, n);
        tests_run++;
        if ({n, result8, ovf8, cy8, zero8} !== {32'd9, 8'hFC, 3'b000}) begin
            tests_failed++;
            $display("FAIL or_f0_3c: got n=%0d %h v/c/z=%b expected n=9 fc 000", n, result8, {ovf8, cy8, zero8});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_held();
        int pulses;
        int n;
        op8 = OP_ADD; opa8 = 8'h10; opb8 = 8'h20; start8 = 1'b1;
        pulses = 0;
        // start stays high through RUN; it is dropped in the DONE cycle.
        repeat (14) begin
            @(posedge clk); #1;
            if (done8) begin
                pulses++;
                start8 = 1'b0;
            end
        end
        start8 = 1'b0;
        tests_run++;
        if (pulses !== 1) begin
            tests_failed++;
            $display("FAIL held_start_pulses: got %0d expected 1", pulses);
        end
        tests_run++;
        if ({busy8, result8} !== {1'b0, 8'h30}) begin
            tests_failed++;
            $display("FAIL held_start_result: got busy=%b %h expected 0 30", busy8, result8);
        end
        run8(OP_OR, 8'h01, 8'h02, n);
        tests_run++;
        if ({n, result8} !== {32'd9, 8'h03}) begin
            tests_failed++;
            $display("FAIL held_start_next_op: got n=%0d %h expected n=9 03", n, result8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int n;
        op8 = OP_ADD; opa8 = 8'hFF; opb8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({busy8, done8, result8, zero8, ovf8, cy8} !== 13'b0) begin
            tests_failed++;
            $display("FAIL mid_run_reset: got b/d=%b %h z/v/c=%b expected 00 00 000",
                     {busy8, done8}, result8, {zero8, ovf8, cy8});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run8(OP_ADD, 8'h03, 8'h04, n);
        tests_run++;
        if ({n, result8, zero8} !== {32'd9, 8'h07, 1'b0}) begin
            tests_failed++;
            $display("FAIL add_after_reset: got n=%0d %h z=%b expected n=9 07 0", n, result8, zero8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_width32();
        int n;
        op32 = OP_ADD; opa32 = 32'hFFFF_FFFF; opb32 = 32'h0000_0001; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        n = 1;
        while (!done32 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (n !== 33) begin
            tests_failed++;
            $display("FAIL w32_latency: got %0d expected 33", n);
        end
        tests_run++;
        if ({result32, zero32, cy32, ovf32} !== {32'h0, 3'b110}) begin
            tests_failed++;
            $display("FAIL w32_add_ffffffff_1: got %h z/c/v=%b expected 00000000 110", result32, {zero32, cy32, ovf32});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_start_held();
        test_reset_mid_run();
        test_width32();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
